// File: rtl/kernel_window_streamer.sv
// 3x3 neighbourhood generator over a raster-order pixel stream, two line buffers deep.
// Define KWIN_BORDER_ZERO_EN to also emit zeroed border windows (adds the FLUSH state).
module kernel_window_streamer #(
  parameter int ROWS = 242,
  parameter int COLS = 247,
  parameter int DW   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DW-1:0]            s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [9*DW-1:0]          m_win,
  output logic [$clog2(ROWS)-1:0]  m_row,
  output logic [$clog2(COLS)-1:0]  m_col,
  output logic                     m_border,
  output logic                     m_last
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
`ifndef KWIN_BORDER_ZERO_EN
  localparam logic [RW-1:0] PEN_ROW = RW'(ROWS - 2);
  localparam logic [CW-1:0] PEN_COL = CW'(COLS - 2);
`endif

  typedef enum logic [1:0] {
    FILL,
    RUN
`ifdef KWIN_BORDER_ZERO_EN
    , FLUSH
`endif
  } state_t;

  state_t r_state, w_stateNxt;

  logic [RW-1:0]    r_inRow, r_cRow;
  logic [CW-1:0]    r_inCol, r_cCol;
  logic [DW-1:0]    r_lbTop [COLS];
  logic [DW-1:0]    r_lbMid [COLS];
  logic [DW-1:0]    r_win   [3][3];
  logic [DW-1:0]    w_win   [3][3];
  logic [9*DW-1:0]  w_winFlat;
  logic             r_mValid, r_mLast;
  logic [9*DW-1:0]  r_mWin;
  logic [RW-1:0]    r_mRow;
  logic [CW-1:0]    r_mCol;
`ifdef KWIN_BORDER_ZERO_EN
  logic             r_mBorder;
`endif
  logic w_held, w_sReady, w_accept, w_load, w_advCentre;
  logic w_frameEnd, w_cBorder, w_cLast;

  assign w_held     = r_mValid & ~m_ready;
  assign w_accept   = s_valid & w_sReady;
  assign w_frameEnd = (r_inRow == LAST_ROW) && (r_inCol == LAST_COL);
  assign w_cBorder  = (r_cRow == '0) || (r_cRow == LAST_ROW) ||
                      (r_cCol == '0) || (r_cCol == LAST_COL);
`ifdef KWIN_BORDER_ZERO_EN
  assign w_sReady = (r_state != FLUSH) & ~w_held;
  assign w_cLast  = (r_cRow == LAST_ROW) && (r_cCol == LAST_COL);
`else
  assign w_sReady = ~w_held;
  assign w_cLast  = (r_cRow == PEN_ROW) && (r_cCol == PEN_COL);
`endif
  // Gated by rst_n so the block refuses pixels while reset is held.
  assign s_ready = rst_n & w_sReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_stateNxt;
  end

  always_comb begin
    w_stateNxt  = r_state;
    w_load      = 1'b0;
    w_advCentre = 1'b0;
    case (r_state)
      FILL: begin
        if (w_accept && (r_inRow == RW'(1)) && (r_inCol == '0)) w_stateNxt = RUN;
      end
      RUN: begin
        if (w_accept) begin
          w_advCentre = 1'b1;
`ifdef KWIN_BORDER_ZERO_EN
          w_load = 1'b1;
          if (w_frameEnd) w_stateNxt = FLUSH;
`else
          w_load = ~w_cBorder;
          if (w_frameEnd) w_stateNxt = FILL;
`endif
        end
      end
`ifdef KWIN_BORDER_ZERO_EN
      // Bottom-row centres have no further input; emit them one per output slot.
      FLUSH: begin
        if (!r_mValid || m_ready) begin
          if (r_mValid && r_mLast) begin
            w_stateNxt = FILL;
          end else begin
            w_load      = 1'b1;
            w_advCentre = 1'b1;
          end
        end
      end
`endif
      default: w_stateNxt = FILL;
    endcase
  end

  // Newest column enters at kj=2: top from two rows up, middle from one row up.
  always_comb begin
    w_winFlat = '0;
    for (int ki = 0; ki < 3; ki++) begin
      w_win[ki][0] = r_win[ki][1];
      w_win[ki][1] = r_win[ki][2];
    end
    w_win[0][2] = r_lbTop[r_inCol];
    w_win[1][2] = r_lbMid[r_inCol];
    w_win[2][2] = s_data;
    for (int ki = 0; ki < 3; ki++)
      for (int kj = 0; kj < 3; kj++)
        w_winFlat[(ki*3+kj)*DW +: DW] = w_win[ki][kj];
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lbTop[r_inCol] <= r_lbMid[r_inCol];
      r_lbMid[r_inCol] <= s_data;
      for (int ki = 0; ki < 3; ki++)
        for (int kj = 0; kj < 3; kj++)
          r_win[ki][kj] <= w_win[ki][kj];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inRow   <= '0;
      r_inCol   <= '0;
      r_cRow    <= '0;
      r_cCol    <= '0;
      r_mValid  <= 1'b0;
      r_mWin    <= '0;
      r_mRow    <= '0;
      r_mCol    <= '0;
      r_mLast   <= 1'b0;
`ifdef KWIN_BORDER_ZERO_EN
      r_mBorder <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        if (r_inCol == LAST_COL) begin
          r_inCol <= '0;
          r_inRow <= (r_inRow == LAST_ROW) ? '0 : r_inRow + 1'b1;
        end else begin
          r_inCol <= r_inCol + 1'b1;
        end
      end
      // Centre position restarts whenever a frame's output sequence is complete.
      if ((w_stateNxt == FILL) && (r_state != FILL)) begin
        r_cRow <= '0;
        r_cCol <= '0;
      end else if (w_advCentre) begin
        if (r_cCol == LAST_COL) begin
          r_cCol <= '0;
          r_cRow <= (r_cRow == LAST_ROW) ? '0 : r_cRow + 1'b1;
        end else begin
          r_cCol <= r_cCol + 1'b1;
        end
      end
      if (w_load) begin
        r_mValid  <= 1'b1;
        r_mWin    <= w_cBorder ? '0 : w_winFlat;
        r_mRow    <= r_cRow;
        r_mCol    <= r_cCol;
        r_mLast   <= w_cLast;
`ifdef KWIN_BORDER_ZERO_EN
        r_mBorder <= w_cBorder;
`endif
      end else if (m_ready) begin
        r_mValid <= 1'b0;
      end
    end
  end

  assign m_valid = r_mValid;
  assign m_win   = r_mWin;
  assign m_row   = r_mRow;
  assign m_col   = r_mCol;
  assign m_last  = r_mLast;
`ifdef KWIN_BORDER_ZERO_EN
  assign m_border = r_mBorder;
`else
  assign m_border = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_window_streamer.sv
// Scoreboard bench for kernel_window_streamer on a 4x5 image; expectations follow
// KWIN_BORDER_ZERO_EN the same way the design does.
module tb_kernel_window_streamer;

  localparam int ROWS = 4;
  localparam int COLS = 5;
  localparam int DW   = 8;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int NPIX = ROWS * COLS;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   s_data;
  logic            m_valid;
  logic            m_ready;
  logic [9*DW-1:0] m_win;
  logic [RW-1:0]   m_row;
  logic [CW-1:0]   m_col;
  logic            m_border;
  logic            m_last;

  int checks   = 0;
  int failures = 0;
  int nModel   = 0;

  typedef struct {
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic            border;
    logic            last;
    logic [9*DW-1:0] win;
    logic            flush;
  } exp_t;

  exp_t sbQ[$];

  always #5 clk = ~clk;

  kernel_window_streamer #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_win(m_win),
    .m_row(m_row), .m_col(m_col), .m_border(m_border), .m_last(m_last)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pixel value at frame index n is base+n, so every neighbour is an index sum.
  function automatic logic [9*DW-1:0] winOf(input int base, input int r, input int c);
    logic [9*DW-1:0] w;
    w = '0;
    for (int ki = 0; ki < 3; ki++)
      for (int kj = 0; kj < 3; kj++)
        w[(ki*3+kj)*DW +: DW] = DW'(base + (r+ki-1)*COLS + (c+kj-1));
    return w;
  endfunction

  function automatic exp_t mkExp(input int base, input int p, input logic last, input logic flush);
    exp_t e;
    int r, c;
    r = p / COLS;
    c = p % COLS;
    e.row   = RW'(r);
    e.col   = CW'(c);
    e.last  = last;
    e.flush = flush;
`ifdef KWIN_BORDER_ZERO_EN
    e.border = (r == 0) || (r == ROWS-1) || (c == 0) || (c == COLS-1);
    e.win    = e.border ? '0 : winOf(base, r, c);
`else
    e.border = 1'b0;
    e.win    = winOf(base, r, c);
`endif
    return e;
  endfunction

  task automatic modelAccept(input int base);
    int p;
    if (nModel >= COLS + 1) begin
      p = nModel - COLS - 1;
`ifdef KWIN_BORDER_ZERO_EN
      sbQ.push_back(mkExp(base, p, 1'b0, 1'b0));
`else
      if ((p / COLS != 0) && (p / COLS != ROWS-1) && (p % COLS != 0) && (p % COLS != COLS-1))
        sbQ.push_back(mkExp(base, p, p == (ROWS-2)*COLS + COLS-2, 1'b0));
`endif
    end
`ifdef KWIN_BORDER_ZERO_EN
    if (nModel == NPIX-1)
      for (int q = NPIX-COLS-1; q < NPIX; q++)
        sbQ.push_back(mkExp(base, q, q == NPIX-1, 1'b1));
`endif
    nModel = (nModel == NPIX-1) ? 0 : nModel + 1;
  endtask

  // Called on a falling edge; offers pixels and waits (bounded) for s_ready.
  task automatic applyStimulus(input int base, input int count);
    for (int i = 0; i < count; i++) begin
      int guard;
      guard   = 0;
      s_valid = 1'b1;
      s_data  = DW'(base + nModel);
      #1;
      while (!s_ready && guard < 200) begin
        @(negedge clk);
        #1;
        guard++;
      end
      if (!s_ready) begin
        checks++;
        failures++;
        $display("[TB] FAIL input_timeout: pixel %0d never accepted, got s_ready=0 expected 1", nModel);
        return;
      end
      modelAccept(base);
      @(negedge clk);
    end
  endtask

  task automatic stallTask();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!m_valid && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!m_valid) begin
      checks++;
      failures++;
      $display("[TB] FAIL first_window_timeout: got m_valid=0 expected 1");
      return;
    end
    m_ready = 1'b0;
    repeat (5) @(negedge clk);
    m_ready = 1'b1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sbQ.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    #3;
    checkOutput("drain_queue_empty", 128'(sbQ.size()), 128'd0);
    repeat (10) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    logic held;
    logic [127:0] snap, hSnap;
    held  = 1'b0;
    hSnap = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        snap = 128'({m_row, m_col, m_border, m_last, m_win});
        if (held) checkOutput("hold_stable", snap, hSnap);
        if (m_valid && !m_ready) begin
          checkOutput("stall_s_ready", 128'(s_ready), 128'd0);
          held  = 1'b1;
          hSnap = snap;
        end else begin
          held = 1'b0;
        end
        if (m_valid && m_ready) begin
          if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_window: got centre (%0d,%0d) expected none", m_row, m_col);
          end else begin
            e = sbQ.pop_front();
            checkOutput("window", snap, 128'({e.row, e.col, e.border, e.last, e.win}));
`ifdef KWIN_BORDER_ZERO_EN
            if (e.flush) checkOutput("flush_s_ready", 128'(s_ready), 128'd0);
`endif
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    #12;
    checkOutput("reset_m_valid",  128'(m_valid),  128'd0);
    checkOutput("reset_m_win",    128'(m_win),    128'd0);
    checkOutput("reset_m_row",    128'(m_row),    128'd0);
    checkOutput("reset_m_col",    128'(m_col),    128'd0);
    checkOutput("reset_m_border", 128'(m_border), 128'd0);
    checkOutput("reset_m_last",   128'(m_last),   128'd0);
    checkOutput("reset_s_ready",  128'(s_ready),  128'd0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    #1 checkOutput("release_s_ready", 128'(s_ready), 128'd1);
    @(negedge clk);

    // Two back-to-back frames with a 5-cycle output stall after the first window.
    fork
      begin
        applyStimulus(0, NPIX);
        applyStimulus(NPIX, NPIX);
      end
      stallTask();
    join
    s_valid = 1'b0;
    drain();

    // Partial frame interrupted by an asynchronous reset.
    applyStimulus(100, 9);
    s_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checkOutput("midreset_m_valid",  128'(m_valid),  128'd0);
    checkOutput("midreset_m_win",    128'(m_win),    128'd0);
    checkOutput("midreset_m_row",    128'(m_row),    128'd0);
    checkOutput("midreset_m_col",    128'(m_col),    128'd0);
    checkOutput("midreset_m_border", 128'(m_border), 128'd0);
    checkOutput("midreset_m_last",   128'(m_last),   128'd0);
    checkOutput("midreset_s_ready",  128'(s_ready),  128'd0);
    sbQ.delete();
    nModel = 0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    #1 checkOutput("midrelease_s_ready", 128'(s_ready), 128'd1);
    @(negedge clk);

    applyStimulus(0, NPIX);
    s_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kernel_window_streamer.md
# kernel_window_streamer

Streaming 3x3 neighbourhood generator that feeds the compass-kernel convolution stage. It accepts a raster-order pixel stream with valid/ready handshake and buffers two image rows. For every kernel centre it emits a 3x3 window in raster order, with the centre's row/column, a border flag and an end-of-frame marker. It is the producer side of the kernel-application interface: it supplies the zero-padded neighbourhoods that the convolution consumes.

## Interface
- ROWS, 242, image rows (>= 3)
- COLS, 247, image columns (>= 3)
- DW, 8, pixel width, signed two's complement
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input pixel valid
- s_ready  out  1  block accepts pixel this cycle
- s_data  in  DW  input pixel, raster order
- m_valid  out  1  window valid
- m_ready  in  1  downstream accepts window
- m_win  out  9*DW  window; element k = ki*3+kj at bits [k*DW+DW-1 : k*DW], ki/kj = 0..2 map to offsets -1..+1 (top-left = k0)
- m_row  out  $clog2(ROWS)  centre row
- m_col  out  $clog2(COLS)  centre column
- m_border  out  1  centre lies on image border
- m_last  out  1  last window of frame

## Operation
- Transfer occurs when valid && ready on either port. Input index n = r*COLS + c counts accepted pixels. Frame wraps to n=0 after pixel ROWS*COLS-1.
- Storage:
  - two COLS-deep line buffers of DW;
  - a 3x3 register window;
  - the output register.
- Centre p = n-(COLS+1) is complete when pixel n is accepted.
- States:
  - FILL: n < COLS+1. No output. s_ready=1 unless output register is still held (m_valid && !m_ready). Accepting pixel n=COLS → RUN.
  - RUN: s_ready = !m_valid || m_ready. Each accepted pixel loads the window for centre p into the output register. The last pixel of the frame → FLUSH (border mode) or FILL (interior mode).
  - FLUSH: s_ready=0. Emits the remaining COLS+1 centres, ROWS*COLS-COLS-1 .. ROWS*COLS-1, one per output handshake slot. All of these are border windows. After the window with m_last → FILL with n=0.
- Border centre: r==0 || r==ROWS-1 || c==0 || c==COLS-1. For border centres, m_win=0 (all nine elements) and m_border=1. For interior centres, m_win holds the actual neighbours and m_border=0.
- m_last=1 only on the final window emitted for the frame.
- Reset mid-frame: all counters, state and the output register clear. Buffered rows are discarded. The next accepted pixel is (0,0) of a new frame.

## Timing
- Output is registered. m_valid rises the cycle after the input handshake that completes a centre (RUN) or the cycle after the previous output handshake (FLUSH).
- m_valid and all m_* signals are held stable while m_valid && !m_ready.
- Full throughput: one window per cycle in RUN with s_valid=m_ready=1.
- Simultaneous output handshake and input handshake in RUN: the register is replaced the same edge, with no bubble.
- Line-buffer read and write at the same column in the same cycle returns the old (pre-write) data.
- Reset values:
  - m_valid=0, m_win=0, m_row=0, m_col=0, m_border=0, m_last=0;
  - state=FILL, n=0;
  - s_ready=0 while rst_n low, 1 in the first cycle after release.

## Configuration
- KWIN_BORDER_ZERO_EN defined:
  - one window per pixel position (ROWS*COLS per frame), including zeroed border windows;
  - FLUSH state present.
- Undefined:
  - only interior centres emitted ((ROWS-2)*(COLS-2) per frame);
  - m_border is constant 0;
  - no FLUSH; the last frame pixel goes to FILL;
  - m_last accompanies centre (ROWS-2, COLS-2).

## Test plan
- ROWS=4, COLS=5, s_data=n, m_ready=1 → centre (1,1) emitted the cycle after n=12 is accepted, with m_win = {0,1,2,5,6,7,10,11,12} for k0..k8 and m_border=0.
- Same stimulus, KWIN_BORDER_ZERO_EN defined → 20 windows in raster order; 14 with m_border=1 and m_win=0; the last 6 arrive during FLUSH with s_ready=0; m_last on (3,4).
- Same stimulus, macro undefined → exactly 6 windows, centres (1,1)..(2,3); m_last on (2,3); no FLUSH cycles.
- m_ready low for 5 cycles after the first window → m_* held constant, s_ready=0, no pixel lost; the sequence resumes intact.
- Two back-to-back frames, s_valid always 1 → the second frame's first window (centre (0,0), border) follows the first frame's m_last with correct row/col restart.
- rst_n pulsed low after 9 pixels → all outputs 0 asynchronously; 20 fresh pixels reproduce scenario 1/2 exactly.
